// File: rtl/adder_pkg.sv
// Shared types and helpers for pipelined_flag_adder: result flag bundle,
// parity helper and the WIDTH/CHUNK legality check.
package adder_pkg;

  // Upper bound on WIDTH; the parity helper zero-extends to this size.
  localparam int PARITY_MAX_W = 256;

  typedef struct packed {
    logic zero;
    logic carry;
    logic sign;
    logic parity;
    logic overflow;
  } flags_t;

  // Even parity: 1 when v holds an even number of ones (zero padding is neutral).
  function automatic logic parity_even(input logic [PARITY_MAX_W-1:0] v);
    return ~^v;
  endfunction

  // WIDTH must split into at least two whole CHUNK-bit stages.
  function automatic bit chunk_ok(input int width, input int chunk);
    return (chunk > 0) && (width % chunk == 0) && (width / chunk >= 2) &&
           (width <= PARITY_MAX_W);
  endfunction

endpackage

// File: rtl/adder_chunk_stage.sv
// One pipeline stage: CHUNK-bit add with carry in/out, plus an enable-qualified
// register for the stage result and the beat's side-band payload.
module adder_chunk_stage #(
  parameter int CHUNK = 4,
  parameter int PW    = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             valid_in,
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  input  logic [PW-1:0]    pass_in,
  output logic             valid_out,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic [PW-1:0]    pass_out
);

  logic [CHUNK:0] full;
  logic           c_msb;

  assign full  = {1'b0, a} + {1'b0, b} + (CHUNK+1)'(cin);
  // Carry into the chunk MSB, recovered from the MSB sum bit.
  assign c_msb = a[CHUNK-1] ^ b[CHUNK-1] ^ full[CHUNK-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_out <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      pass_out  <= '0;
    end else if (en) begin
      valid_out <= valid_in;
      sum       <= full[CHUNK-1:0];
      cout      <= full[CHUNK];
      ovf       <= c_msb ^ full[CHUNK];
      pass_out  <= pass_in;
    end
  end

endmodule

// File: rtl/pipelined_flag_adder.sv
// WIDTH-bit adder pipelined in CHUNK-bit carry stages with Z/C/S/P/V flags and
// valid/ready back-pressure. Optional subtract mode: define ADDER_SUB_EN.
module pipelined_flag_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             sign,
  output logic             parity,
  output logic             overflow,
  output logic             zero
);

  localparam int  STAGES   = WIDTH / CHUNK;
  localparam int  PW       = 3 * WIDTH + 1;
  localparam bit  CHUNK_OK = chunk_ok(WIDTH, CHUNK);

  if (!CHUNK_OK) begin : g_bad_cfg
    $error("pipelined_flag_adder: WIDTH must be a multiple of CHUNK with at least two stages");
  end

  logic                         pipe_en;
  logic                         accept;
  logic                         sub_sel;
  logic [STAGES:1]              vld_pipe;
  logic [STAGES:0][WIDTH-1:0]   ah;
  logic [STAGES:0][WIDTH-1:0]   bh;
  logic [STAGES:0][WIDTH-1:0]   acc;
  logic [STAGES:0]              carry_c;
  logic [STAGES:0]              sb;
  logic [STAGES-1:0]            ovf_s;
  flags_t                       flags;
  logic                         unused_bits;

`ifdef ADDER_SUB_EN
  assign sub_sel = sub;
`else
  assign sub_sel = 1'b0;
`endif

  assign pipe_en  = !out_valid || out_ready;
  assign in_ready = pipe_en;
  assign accept   = in_valid && pipe_en;

  // Subtract is a + ~b + !cin; the mode bit rides along to fix up the borrow.
  assign ah[0]      = a;
  assign bh[0]      = sub_sel ? ~b : b;
  assign carry_c[0] = cin ^ sub_sel;
  assign sb[0]      = sub_sel;
  assign acc[0]     = '0;

  // Operands shift right one chunk per stage so each stage reads the low chunk;
  // finished sum chunks enter at the top and shift down into place.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic             v_in;
    logic [CHUNK-1:0] s_q;
    logic [WIDTH-1:0] acc_sh;
    logic [PW-1:0]    p_q;

    if (k == 0) begin : g_first
      assign v_in = accept;
    end else begin : g_rest
      assign v_in = vld_pipe[k];
    end

    adder_chunk_stage #(.CHUNK(CHUNK), .PW(PW)) u_stage (
      .clk      (clk),
      .rst      (rst),
      .en       (pipe_en),
      .valid_in (v_in),
      .a        (ah[k][CHUNK-1:0]),
      .b        (bh[k][CHUNK-1:0]),
      .cin      (carry_c[k]),
      .pass_in  ({sb[k], ah[k] >> CHUNK, bh[k] >> CHUNK, acc[k] >> CHUNK}),
      .valid_out(vld_pipe[k+1]),
      .sum      (s_q),
      .cout     (carry_c[k+1]),
      .ovf      (ovf_s[k]),
      .pass_out (p_q)
    );

    assign {sb[k+1], ah[k+1], bh[k+1], acc_sh} = p_q;
    assign acc[k+1] = acc_sh | (WIDTH'(s_q) << (WIDTH - CHUNK));
  end

  assign out_valid = vld_pipe[STAGES];

  // Zero is qualified by valid so the idle/reset state reads zero=0.
  always_comb begin
    flags          = '0;
    flags.zero     = vld_pipe[STAGES] && ~|acc[STAGES];
    flags.carry    = carry_c[STAGES] ^ sb[STAGES];
    flags.sign     = acc[STAGES][WIDTH-1];
    flags.parity   = parity_even(PARITY_MAX_W'(acc[STAGES]));
    flags.overflow = ovf_s[STAGES-1];
  end

  assign sum      = acc[STAGES];
  assign zero     = flags.zero;
  assign carry    = flags.carry;
  assign sign     = flags.sign;
  assign parity   = flags.parity;
  assign overflow = flags.overflow;

  assign unused_bits = ^{ah[STAGES], bh[STAGES], ovf_s};

endmodule

// File: tb/tb_pipelined_flag_adder.sv
// Directed + randomized bench for pipelined_flag_adder against an arithmetic
// reference model with an in-order expected-result queue.
`timescale 1ns/1ps
module tb_pipelined_flag_adder;
  localparam int W = 16;
  localparam int C = 4;
  localparam int S = W / C;

  typedef struct {
    logic [W-1:0] s;
    logic c, o, sg, p, z;
    int t;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0, cin = 1'b0;
  logic [W-1:0] a = '0, b = '0, sum;
  logic carry, sign, parity, overflow, zero;
`ifdef ADDER_SUB_EN
  logic sub = 1'b0;
`endif

  int tests = 0, fails = 0, cyc = 0;
  exp_t q[$];
  exp_t gold;
  logic use_gold = 1'b0;
  logic lat_chk = 1'b0;
  logic held = 1'b0;
  logic [W+4:0] held_val = '0;

  always #5 clk = ~clk;

  pipelined_flag_adder #(.WIDTH(W), .CHUNK(C)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin),
`ifdef ADDER_SUB_EN
    .sub(sub),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .carry(carry),
    .sign(sign), .parity(parity), .overflow(overflow), .zero(zero)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic ci, input logic sb);
    exp_t e;
    logic [W:0] t;
    if (sb) t = {1'b0, x} - {1'b0, y} - (W+1)'(ci);
    else    t = {1'b0, x} + {1'b0, y} + (W+1)'(ci);
    e.s  = t[W-1:0];
    e.c  = t[W];
    e.sg = t[W-1];
    e.z  = (t[W-1:0] == '0);
    e.p  = ~^t[W-1:0];
    if (sb) e.o = (x[W-1] != y[W-1]) && (t[W-1] != x[W-1]);
    else    e.o = (x[W-1] == y[W-1]) && (t[W-1] != x[W-1]);
    e.t = 0;
    return e;
  endfunction

  task automatic check_out(input exp_t e);
    chk("sum", sum, e.s);
    chk("carry", carry, e.c);
    chk("overflow", overflow, e.o);
    chk("sign", sign, e.sg);
    chk("parity", parity, e.p);
    chk("zero", zero, e.z);
  endtask

  // One clock cycle: drive at the falling edge, check 1ns later, book-keep.
  task automatic step(input logic iv, input logic [W-1:0] ia, input logic [W-1:0] ib,
                      input logic ic, input logic isb, input logic ordy, output logic acc);
    exp_t e;
    in_valid = iv; a = ia; b = ib; cin = ic; out_ready = ordy;
`ifdef ADDER_SUB_EN
    sub = isb;
`endif
    #1;
    if (held) begin
      chk("hold_valid", out_valid, 1'b1);
      chk("hold_data", {sum, carry, sign, parity, overflow, zero}, held_val);
    end
    chk("in_ready_rule", in_ready, !out_valid || ordy);
    if (out_valid && ordy) begin
      if (q.size() == 0) chk("spurious_out", out_valid, 1'b0);
      else begin
        e = q.pop_front();
        check_out(e);
        if (lat_chk) chk("latency", cyc - e.t, S);
      end
    end
    acc = iv && in_ready;
    if (acc) begin
      e = use_gold ? gold : model(ia, ib, ic, isb);
      e.t = cyc;
      q.push_back(e);
    end
    held = out_valid && !ordy;
    held_val = {sum, carry, sign, parity, overflow, zero};
    @(negedge clk);
    cyc++;
  endtask

  task automatic dir(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci,
                     input logic sb, input logic [W-1:0] es, input logic ec,
                     input logic eo, input logic esg, input logic ep, input logic ez);
    logic ac;
    gold.s = es; gold.c = ec; gold.o = eo; gold.sg = esg; gold.p = ep; gold.z = ez;
    gold.t = 0;
    use_gold = 1'b1;
    step(1'b1, x, y, ci, sb, 1'b1, ac);
    use_gold = 1'b0;
    chk("dir_accept", ac, 1'b1);
    repeat (S) step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, ac);
    chk("dir_drained", q.size(), 0);
  endtask

  initial begin
    logic ac;
    logic [W-1:0] va[6], vb[6], ra, rb;
    logic vc[6];
    logic rc, rs;
    int idx, k;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_sum", sum, 16'h0000);
    chk("rst_flags", {carry, sign, overflow, zero, parity}, 5'b00001);
    @(negedge clk);

    lat_chk = 1'b1;
    dir(16'hA6C3, 16'hA22E, 1'b1, 1'b0, 16'h48F2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    dir(16'h36C3, 16'h022E, 1'b0, 1'b0, 16'h38F1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    dir(16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    dir(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    dir(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    dir(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
`ifdef ADDER_SUB_EN
    dir(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    dir(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
`endif
    lat_chk = 1'b0;

    // Six back-to-back beats with out_ready low while the first result is up.
    for (int i = 0; i < 6; i++) begin
      va[i] = W'($urandom); vb[i] = W'($urandom); vc[i] = 1'($urandom_range(0, 1));
    end
    idx = 0; k = 0;
    while ((idx < 6 || q.size() != 0) && k < 40) begin
      if (idx < 6) step(1'b1, va[idx], vb[idx], vc[idx], 1'b0, !(k >= 4 && k <= 6), ac);
      else         step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, ac);
      if (ac) idx++;
      k++;
    end
    chk("stall_all_accepted", idx, 6);
    chk("stall_drained", q.size(), 0);

    // Reset with three beats still in the pipe.
    for (int i = 0; i < 3; i++) step(1'b1, W'($urandom), W'($urandom), 1'b1, 1'b0, 1'b1, ac);
    rst = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    cyc++;
    rst = 1'b0; held = 1'b0; q.delete();
    #1;
    chk("mid_rst_out_valid", out_valid, 1'b0);
    chk("mid_rst_sum", sum, 16'h0000);
    chk("mid_rst_flags", {carry, sign, overflow, zero, parity}, 5'b00001);
    repeat (8) step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, ac);

    // Random traffic with random back-pressure.
    ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom_range(0, 1)); rs = 1'b0;
    repeat (300) begin
      step($urandom_range(0, 3) != 0, ra, rb, rc, rs, $urandom_range(0, 3) != 0, ac);
      if (ac) begin
        ra = ($urandom_range(0, 7) == 0) ? 16'hFFFF : W'($urandom);
        rb = ($urandom_range(0, 7) == 0) ? 16'h8000 : W'($urandom);
        rc = 1'($urandom_range(0, 1));
`ifdef ADDER_SUB_EN
        rs = 1'($urandom_range(0, 1));
`endif
      end
    end
    k = 0;
    while (q.size() != 0 && k < 50) begin
      step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, ac);
      k++;
    end
    chk("random_drained", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
